// File: rtl/rps_score_engine.sv
// Two-stage rock-paper-scissors round scorer: decode/resolve in stage 1, accumulate in stage 2.
// Define RPS_SAT_EN to clamp totals at their maximum instead of wrapping.
module rps_score_engine #(
    parameter int SCORE_W = 16,
    parameter int ROUND_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_p1,
    input  logic [1:0]         in_p2,
    input  logic               in_mode,
    input  logic               in_last,
    output logic               res_valid,
    output logic [1:0]         res_outcome,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [ROUND_W-1:0] rounds,
    output logic               done,
    output logic               error,
    output logic               overflow
);

    localparam logic [1:0] OUT_LOSE = 2'b01;
    localparam logic [1:0] OUT_DRAW = 2'b10;
    localparam logic [1:0] OUT_WIN  = 2'b11;

    // Shape that defeats s (rock->paper, paper->scissors, scissors->rock).
    function automatic logic [1:0] beater(input logic [1:0] s);
        case (s)
            2'b01:   beater = 2'b10;
            2'b10:   beater = 2'b11;
            2'b11:   beater = 2'b01;
            default: beater = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] beaten(input logic [1:0] s);
        case (s)
            2'b01:   beaten = 2'b11;
            2'b10:   beaten = 2'b01;
            2'b11:   beaten = 2'b10;
            default: beaten = 2'b00;
        endcase
    endfunction

    logic       accept;
    logic       invalid;
    logic [1:0] dec_p2;
    logic [1:0] dec_outcome;

    logic       s1_valid;
    logic [1:0] s1_p1;
    logic [1:0] s1_p2;
    logic [1:0] s1_outcome;
    logic       s1_last;

    logic [3:0]         p1_pts;
    logic [3:0]         p2_pts;
    logic [SCORE_W:0]   p1_sum;
    logic [SCORE_W:0]   p2_sum;
    logic [SCORE_W-1:0] p1_next;
    logic [SCORE_W-1:0] p2_next;

    assign in_ready = ~error & ~done & ~clear;
    assign accept   = in_valid & in_ready;
    assign invalid  = (in_p1 == 2'b00) | (in_p2 == 2'b00);

    always_comb begin
        dec_p2      = in_p2;
        dec_outcome = OUT_DRAW;
        if (in_mode) begin
            dec_outcome = in_p2;
            case (in_p2)
                OUT_LOSE: dec_p2 = beaten(in_p1);
                OUT_WIN:  dec_p2 = beater(in_p1);
                default:  dec_p2 = in_p1;
            endcase
        end else if (in_p2 == in_p1) begin
            dec_outcome = OUT_DRAW;
        end else if (in_p2 == beater(in_p1)) begin
            dec_outcome = OUT_WIN;
        end else begin
            dec_outcome = OUT_LOSE;
        end
    end

    // Outcome is from player2's view, so player1's bonus mirrors it.
    always_comb begin
        p1_pts = {2'b00, s1_p1};
        p2_pts = {2'b00, s1_p2};
        case (s1_outcome)
            OUT_LOSE: p1_pts = p1_pts + 4'd6;
            OUT_WIN:  p2_pts = p2_pts + 4'd6;
            default: begin
                p1_pts = p1_pts + 4'd3;
                p2_pts = p2_pts + 4'd3;
            end
        endcase
        p1_sum = {1'b0, p1_score} + {{(SCORE_W-3){1'b0}}, p1_pts};
        p2_sum = {1'b0, p2_score} + {{(SCORE_W-3){1'b0}}, p2_pts};
`ifdef RPS_SAT_EN
        p1_next = p1_sum[SCORE_W] ? {SCORE_W{1'b1}} : p1_sum[SCORE_W-1:0];
        p2_next = p2_sum[SCORE_W] ? {SCORE_W{1'b1}} : p2_sum[SCORE_W-1:0];
`else
        p1_next = p1_sum[SCORE_W-1:0];
        p2_next = p2_sum[SCORE_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            s1_valid    <= 1'b0;
            s1_p1       <= 2'b00;
            s1_p2       <= 2'b00;
            s1_outcome  <= 2'b00;
            s1_last     <= 1'b0;
            res_valid   <= 1'b0;
            res_outcome <= 2'b00;
            p1_score    <= '0;
            p2_score    <= '0;
            rounds      <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            s1_valid  <= 1'b0;
            if (accept) begin
                if (invalid) begin
                    error <= 1'b1;
                end else begin
                    s1_valid   <= 1'b1;
                    s1_p1      <= in_p1;
                    s1_p2      <= dec_p2;
                    s1_outcome <= dec_outcome;
                    s1_last    <= in_last;
                end
            end
            if (s1_valid) begin
                p1_score    <= p1_next;
                p2_score    <= p2_next;
                rounds      <= rounds + ROUND_W'(1);
                res_valid   <= 1'b1;
                res_outcome <= s1_outcome;
                overflow    <= overflow | p1_sum[SCORE_W] | p2_sum[SCORE_W];
                if (s1_last) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rps_score_engine.sv
// Directed bench for rps_score_engine; a second SCORE_W=4 instance covers total overflow.
module tb_rps_score_engine;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [1:0]  in_p1;
    logic [1:0]  in_p2;
    logic        in_mode;
    logic        in_last;

    logic        in_ready;
    logic        res_valid;
    logic [1:0]  res_outcome;
    logic [15:0] p1_score;
    logic [15:0] p2_score;
    logic [11:0] rounds;
    logic        done;
    logic        error;
    logic        overflow;

    logic        sm_in_ready;
    logic        sm_res_valid;
    logic [1:0]  sm_res_outcome;
    logic [3:0]  sm_p1_score;
    logic [3:0]  sm_p2_score;
    logic [11:0] sm_rounds;
    logic        sm_done;
    logic        sm_error;
    logic        sm_overflow;

    logic [49:0] all_out;

    int n_cmp;
    int n_bad;

    assign all_out = {res_valid, res_outcome, p1_score, p2_score, rounds, done, error, overflow};

    rps_score_engine #(.SCORE_W(16), .ROUND_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_p1(in_p1), .in_p2(in_p2), .in_mode(in_mode), .in_last(in_last),
        .res_valid(res_valid), .res_outcome(res_outcome), .p1_score(p1_score),
        .p2_score(p2_score), .rounds(rounds), .done(done), .error(error), .overflow(overflow)
    );

    rps_score_engine #(.SCORE_W(4), .ROUND_W(12)) dut_small (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(sm_in_ready),
        .in_p1(in_p1), .in_p2(in_p2), .in_mode(in_mode), .in_last(in_last),
        .res_valid(sm_res_valid), .res_outcome(sm_res_outcome), .p1_score(sm_p1_score),
        .p2_score(sm_p2_score), .rounds(sm_rounds), .done(sm_done), .error(sm_error),
        .overflow(sm_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] a, input logic [1:0] b, input logic m, input logic l);
        in_valid = 1'b1;
        in_p1    = a;
        in_p2    = b;
        in_mode  = m;
        in_last  = l;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_p1    = 2'b00;
        in_p2    = 2'b00;
        in_mode  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        clear = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (all_out !== 50'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", all_out);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_mode0();
        do_reset();
        put(2'b01, 2'b10, 1'b0, 1'b0); tick();
        put(2'b10, 2'b01, 1'b0, 1'b0); tick();
        put(2'b11, 2'b11, 1'b0, 1'b1); tick();
        idle(); tick();
        n_cmp++;
        if ({p1_score, p2_score} !== {16'd15, 16'd15}) begin
            n_bad++;
            $display("[TB] FAIL mode0_totals: got %0d/%0d expected 15/15", p1_score, p2_score);
        end
        n_cmp++;
        if (rounds !== 12'd3) begin
            n_bad++;
            $display("[TB] FAIL mode0_rounds: got %0d expected 3", rounds);
        end
        n_cmp++;
        if ({done, in_ready, res_outcome} !== {1'b1, 1'b0, 2'b10}) begin
            n_bad++;
            $display("[TB] FAIL mode0_done_ready_outcome: got %b%b%b expected 1010",
                     done, in_ready, res_outcome);
        end
    endtask

    task automatic test_mode1();
        do_reset();
        put(2'b01, 2'b10, 1'b1, 1'b0); tick();
        put(2'b10, 2'b01, 1'b1, 1'b0); tick();
        n_cmp++;
        if ({res_valid, res_outcome, p1_score, p2_score} !== {1'b1, 2'b10, 16'd4, 16'd4}) begin
            n_bad++;
            $display("[TB] FAIL mode1_round1: got v=%b o=%b %0d/%0d expected v=1 o=10 4/4",
                     res_valid, res_outcome, p1_score, p2_score);
        end
        put(2'b11, 2'b11, 1'b1, 1'b0); tick();
        n_cmp++;
        if (res_outcome !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL mode1_outcome2: got %b expected 01", res_outcome);
        end
        idle(); tick();
        n_cmp++;
        if (res_outcome !== 2'b11) begin
            n_bad++;
            $display("[TB] FAIL mode1_outcome3: got %b expected 11", res_outcome);
        end
        n_cmp++;
        if ({p1_score, p2_score, rounds, done} !== {16'd15, 16'd12, 12'd3, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL mode1_totals: got %0d/%0d r=%0d d=%b expected 15/12 r=3 d=0",
                     p1_score, p2_score, rounds, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] seen;
        logic [4:0] want;
        do_reset();
        want = 5'b01110;
        put(2'b01, 2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) idle();
            tick();
            seen[i] = res_valid;
        end
        n_cmp++;
        if (seen !== want) begin
            n_bad++;
            $display("[TB] FAIL b2b_res_valid_train: got %b expected %b", seen, want);
        end
        n_cmp++;
        if ({p1_score, p2_score, rounds} !== {16'd21, 16'd9, 12'd3}) begin
            n_bad++;
            $display("[TB] FAIL b2b_totals: got %0d/%0d r=%0d expected 21/9 r=3",
                     p1_score, p2_score, rounds);
        end
    endtask

    task automatic test_error();
        do_reset();
        put(2'b01, 2'b10, 1'b0, 1'b0); tick();
        put(2'b00, 2'b10, 1'b0, 1'b0); tick();
        put(2'b10, 2'b01, 1'b0, 1'b0); tick();
        tick();
        idle();
        n_cmp++;
        if ({error, in_ready} !== 2'b10) begin
            n_bad++;
            $display("[TB] FAIL error_flag_ready: got %b%b expected 10", error, in_ready);
        end
        n_cmp++;
        if ({p1_score, p2_score, rounds} !== {16'd1, 16'd8, 12'd1}) begin
            n_bad++;
            $display("[TB] FAIL error_totals: got %0d/%0d r=%0d expected 1/8 r=1",
                     p1_score, p2_score, rounds);
        end
        clear = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL clear_in_ready: got %b expected 0", in_ready);
        end
        tick();
        clear = 1'b0;
        #1;
        n_cmp++;
        if ({all_out, in_ready} !== {50'd0, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL clear_outputs: got %h/%b expected 0/1", all_out, in_ready);
        end
    endtask

    task automatic test_clear_midpipe();
        do_reset();
        put(2'b10, 2'b01, 1'b0, 1'b0); tick();
        idle();
        clear = 1'b1; tick();
        clear = 1'b0; tick();
        n_cmp++;
        if ({res_valid, rounds, p1_score} !== {1'b0, 12'd0, 16'd0}) begin
            n_bad++;
            $display("[TB] FAIL clear_midpipe: got v=%b r=%0d p1=%0d expected 0/0/0",
                     res_valid, rounds, p1_score);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] want_small;
`ifdef RPS_SAT_EN
        want_small = 4'd15;
`else
        want_small = 4'd2;
`endif
        do_reset();
        put(2'b11, 2'b11, 1'b0, 1'b0);
        tick(); tick(); tick();
        idle(); tick();
        n_cmp++;
        if ({sm_p1_score, sm_p2_score, sm_overflow} !== {want_small, want_small, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL small_overflow: got %0d/%0d ov=%b expected %0d/%0d ov=1",
                     sm_p1_score, sm_p2_score, sm_overflow, want_small, want_small);
        end
        n_cmp++;
        if ({p1_score, p2_score, overflow} !== {16'd18, 16'd18, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL wide_no_overflow: got %0d/%0d ov=%b expected 18/18 ov=0",
                     p1_score, p2_score, overflow);
        end
    endtask

    task automatic test_rst_midpipe();
        do_reset();
        put(2'b10, 2'b01, 1'b0, 1'b0); tick();
        idle();
        rst_n = 1'b0; tick();
        n_cmp++;
        if (all_out !== 50'd0) begin
            n_bad++;
            $display("[TB] FAIL rst_midpipe_outputs: got %h expected 0", all_out);
        end
        rst_n = 1'b1; tick();
        n_cmp++;
        if ({res_valid, rounds} !== {1'b0, 12'd0}) begin
            n_bad++;
            $display("[TB] FAIL rst_midpipe_no_pulse: got v=%b r=%0d expected 0/0",
                     res_valid, rounds);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        idle();
        test_reset();
        test_mode0();
        test_mode1();
        test_back_to_back();
        test_error();
        test_clear_midpipe();
        test_overflow();
        test_rst_midpipe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
